sweep_ctrl8: RTL and testbench

SWEEP_CTRL8 -- requirements
Module: sweep_ctrl8

---
 rtl/sweep_ctrl8_defs.sv | 14 +
 rtl/sweep_cnt8.sv | 34 +++
 rtl/sweep_ctrl8.sv | 127 ++++++++++++
 tb/tb_sweep_ctrl8.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_ctrl8_defs.sv
// Shared state encoding and default widths for the sweep controller.
package sweep_ctrl8_defs;

    localparam int W_DEF  = 8;
    localparam int NW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sweep_cnt8.sv
// Up/down count register with load and step enable, plus the registered direction flag.
module sweep_cnt8
    import sweep_ctrl8_defs::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic         up,
    input  logic         dir_d,
    output logic [W-1:0] count,
    output logic         dir
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            dir   <= 1'b0;
        end else begin
            dir <= dir_d;
            if (load) begin
                count <= ld_val;
            end else if (en) begin
                count <= up ? (count + ONE) : (count - ONE);
            end
        end
    end

endmodule

// File: rtl/sweep_ctrl8.sv
// Bounded up/down sweep controller: runs lo..hi..lo round trips, a fixed number or continuously.
module sweep_ctrl8
    import sweep_ctrl8_defs::*;
#(
    parameter int W  = W_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [NW-1:0] trips,
    output logic [W-1:0]  count,
    output logic          dir,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state, state_nxt;
    logic [W-1:0]  lo_r, hi_r;
    logic [NW-1:0] trips_r, trip_cnt, trip_plus;
    logic          lat_en, trip_clr, trip_inc, err_nxt;
    logic          cnt_load, cnt_en, cnt_up;

    assign trip_plus = trip_cnt + NW'(1);
    assign busy      = (state == ST_UP) || (state == ST_DOWN);
    assign done      = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        lat_en    = 1'b0;
        trip_clr  = 1'b0;
        trip_inc  = 1'b0;
        err_nxt   = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_up    = 1'b1;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (lo < hi) begin
                        lat_en    = 1'b1;
                        trip_clr  = 1'b1;
                        cnt_load  = 1'b1;
                        state_nxt = ST_UP;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_UP: begin
                // Bound test before stepping keeps count from ever wrapping.
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (count != hi_r) begin
                    cnt_en = 1'b1;
                end else begin
                    cnt_en    = 1'b1;
                    cnt_up    = 1'b0;
                    state_nxt = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (count != lo_r) begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b0;
                end else begin
                    trip_inc = 1'b1;
                    if ((trips_r != '0) && (trip_plus == trips_r)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_en    = 1'b1;
                        state_nxt = ST_UP;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            trips_r  <= '0;
            trip_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (lat_en) begin
                lo_r    <= lo;
                hi_r    <= hi;
                trips_r <= trips;
            end
            if (trip_clr) begin
                trip_cnt <= '0;
            end else if (trip_inc) begin
                trip_cnt <= trip_plus;
            end
        end
    end

    sweep_cnt8 #(.W(W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (cnt_load),
        .ld_val (lo),
        .en     (cnt_en),
        .up     (cnt_up),
        .dir_d  (state_nxt == ST_UP),
        .count  (count),
        .dir    (dir)
    );

endmodule

// File: tb/tb_sweep_ctrl8.sv
// Directed bench for sweep_ctrl8 with a queue-based sweep model checked every cycle.
module tb_sweep_ctrl8;

    logic       clk = 1'b0;
    logic       reset, start, stop;
    logic [7:0] lo, hi, count;
    logic [3:0] trips;
    logic       dir, busy, done, err;

    int n_asrt = 0;
    int n_fail = 0;

    sweep_ctrl8 #(.W(8), .NW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .lo    (lo),
        .hi    (hi),
        .trips (trips),
        .count (count),
        .dir   (dir),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        logic       d;
        logic       b;
        logic       dn;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    logic err_m;
    logic armed = 1'b0;

    // Expand a whole accepted sweep into the per-cycle outputs it must produce.
    function automatic void build(int l, int h, int t);
        int ntr;
        q.delete();
        ntr = (t == 0) ? 16 : t;
        for (int tr = 0; tr < ntr; tr++) begin
            for (int v = (tr == 0) ? l : l + 1; v <= h; v++) q.push_back('{8'(v), 1'b1, 1'b1, 1'b0});
            for (int v = h - 1; v >= l; v--) q.push_back('{8'(v), 1'b0, 1'b1, 1'b0});
        end
        if (t != 0) q.push_back('{8'(l), 1'b0, 1'b0, 1'b1});
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            cur   = '{8'd0, 1'b0, 1'b0, 1'b0};
            err_m = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            err_m = 1'b0;
            if (cur.b && stop) begin
                q.delete();
                cur = '{cur.c, 1'b0, 1'b0, 1'b0};
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else if (cur.dn) begin
                cur = '{cur.c, 1'b0, 1'b0, 1'b0};
            end else if (start) begin
                if (lo < hi) begin
                    build(int'(lo), int'(hi), int'(trips));
                    cur = q.pop_front();
                end else begin
                    err_m = 1'b1;
                end
            end
        end
        #1;
        if (armed) begin
            n_asrt++;
            if (count !== cur.c || dir !== cur.d || busy !== cur.b || done !== cur.dn || err !== err_m) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got count=%0d dir=%b busy=%b done=%b err=%b want count=%0d dir=%b busy=%b done=%b err=%b",
                         $time, count, dir, busy, done, err, cur.c, cur.d, cur.b, cur.dn, err_m);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int exp34[7] = '{2, 3, 4, 5, 4, 3, 2};
    int pat35[6] = '{0, 1, 2, 3, 2, 1};
    int exp38[5] = '{1, 2, 1, 2, 1};

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; lo = '0; hi = '0; trips = '0;
        tick(2);
        chk("rst_count", count, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;

        // single trip, with bound/start changes ignored while busy
        lo = 8'd2; hi = 8'd5; trips = 4'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("trip1_seq", count, exp34[i]);
            chk("trip1_busy", busy, 1);
            if (i == 1) begin start = 1'b1; lo = 8'd0; hi = 8'd9; trips = 4'd0; end
            if (i == 3) begin start = 1'b0; lo = 8'd2; hi = 8'd5; trips = 4'd1; end
            if (i < 6) tick(1);
        end
        tick(1);
        chk("trip1_done", done, 1);
        chk("trip1_done_count", count, 2);
        tick(1);
        chk("trip1_idle_done", done, 0);
        chk("trip1_idle_busy", busy, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_idle_busy", busy, 0);
        chk("stop_idle_count", count, 2);

        // rejected starts
        lo = 8'd7; hi = 8'd7; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("bad_eq_err", err, 1);
        chk("bad_eq_count", count, 2);
        chk("bad_eq_busy", busy, 0);
        tick(1);
        chk("bad_eq_err_clr", err, 0);
        lo = 8'd9; hi = 8'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("bad_lt_err", err, 1);
        tick(1);
        chk("bad_lt_err_clr", err, 0);

        // continuous mode, stopped at the lower turnaround
        lo = 8'd0; hi = 8'd3; trips = 4'd0; start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            chk("cont_seq", count, pat35[k % 6]);
            chk("cont_busy", busy, 1);
            chk("cont_done", done, 0);
            tick(1);
        end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("cont_stop_busy", busy, 0);
        chk("cont_stop_count", count, 0);
        tick(1);
        chk("cont_stop_done", done, 0);

        // stop at the upper turnaround
        lo = 8'd1; hi = 8'd4; trips = 4'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("stophi_pre_count", count, 4);
        chk("stophi_pre_dir", dir, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stophi_busy", busy, 0);
        chk("stophi_count", count, 4);
        chk("stophi_done", done, 0);
        tick(1);
        chk("stophi_done2", done, 0);

        // stop beats completion
        lo = 8'd1; hi = 8'd2; trips = 4'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("stopend_pre_count", count, 1);
        chk("stopend_pre_dir", dir, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stopend_done", done, 0);
        chk("stopend_busy", busy, 0);

        // mid-run reset dominating start/stop, then a two-trip sweep
        lo = 8'd0; hi = 8'd5; trips = 4'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        chk("midrst_pre_count", count, 4);
        chk("midrst_pre_dir", dir, 0);
        reset = 1'b1; start = 1'b1; stop = 1'b1;
        tick(1);
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_busy", busy, 0);
        lo = 8'd1; hi = 8'd2; trips = 4'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("trip2_seq", count, exp38[i]);
            tick(1);
        end
        chk("trip2_done", done, 1);
        chk("trip2_done_count", count, 1);
        tick(1);
        chk("trip2_idle", done, 0);

        // full-range sweep without wrap
        lo = 8'd0; hi = 8'd255; trips = 4'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(255);
        chk("ext_peak", count, 255);
        chk("ext_peak_dir", dir, 1);
        tick(1);
        chk("ext_after_peak", count, 254);
        tick(254);
        chk("ext_bottom", count, 0);
        chk("ext_bottom_busy", busy, 1);
        tick(1);
        chk("ext_done", done, 1);
        chk("ext_done_count", count, 0);
        tick(1);
        chk("ext_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
